// File: rtl/debug_unit.sv
// Host-side UART debug controller: loads instruction memory, runs or steps
// the pipeline, then dumps the register file and data memory over UART.
//
// Ports:
//   i_clk, i_reset                   clock, async active-low reset
//   i_rx_data/i_rx_valid             received UART byte + 1-cycle strobe
//   o_tx_data/o_tx_start/i_tx_done   transmit byte, start pulse, done pulse
//   o_stop                           pipeline freeze (1 = hold)
//   o_write_instruction_mem/_addr/_data  instruction memory write port
//   o_r_addr_registers/i_r_data_registers  regfile debug read (1-cycle latency)
//   o_r_addr_data_mem/i_r_data_data_mem    dmem debug read (1-cycle latency)
//   i_end                            pipeline has retired HALT
module debug_unit #(
   parameter int IMEM_BYTES      = 256,
   parameter int DMEM_DUMP_WORDS = 8,
   parameter int NB_REG_ADDR     = 5
) (
   input  logic                   i_clk,
   input  logic                   i_reset,
   input  logic [7:0]             i_rx_data,
   input  logic                   i_rx_valid,
   output logic [7:0]             o_tx_data,
   output logic                   o_tx_start,
   input  logic                   i_tx_done,
   output logic                   o_stop,
   output logic                   o_write_instruction_mem,
   output logic [31:0]            o_instruction_mem_addr,
   output logic [31:0]            o_instruction_mem_data,
   output logic [NB_REG_ADDR-1:0] o_r_addr_registers,
   output logic [4:0]             o_r_addr_data_mem,
   input  logic [31:0]            i_r_data_registers,
   input  logic [31:0]            i_r_data_data_mem,
   input  logic                   i_end
);

   localparam int NREG      = 1 << NB_REG_ADDR;
   localparam int NWORDS    = NREG + DMEM_DUMP_WORDS;
   localparam int IW        = $clog2(NWORDS);
   localparam logic [IW-1:0] LAST_IDX = IW'(NWORDS - 1);
   localparam logic [IW-1:0] NREG_IDX = IW'(NREG);
   localparam logic [31:0]   LAST_ADDR = 32'(IMEM_BYTES - 4);

   typedef enum logic [3:0] {
      S_IDLE,
      S_LOAD,
      S_WRITE,
      S_RUN,
      S_STEP,
      S_DADDR,
      S_DCAP,
      S_DSEND,
      S_DWAIT
   } state_t;

   state_t        state_q, state_d;
   logic [31:0]   addr_q, addr_d;
   logic [31:0]   word_q, word_d;
   logic [1:0]    cnt_q, cnt_d;
   logic [IW-1:0] idx_q, idx_d;

   logic          is_reg;
   logic [IW-1:0] dm_idx;

   assign is_reg = idx_q < NREG_IDX;
   assign dm_idx = idx_q - NREG_IDX;

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         word_q  <= '0;
         cnt_q   <= '0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         word_q  <= word_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
      end
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      word_d  = word_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      o_stop                  = 1'b1;
      o_write_instruction_mem = 1'b0;
      o_instruction_mem_addr  = '0;
      o_instruction_mem_data  = '0;
      o_tx_start              = 1'b0;
      o_tx_data               = '0;
      o_r_addr_registers      = '0;
      o_r_addr_data_mem       = '0;

      unique case (state_q)
         S_IDLE: begin
            if (i_rx_valid) begin
               if (i_rx_data == 8'h4C) begin
                  state_d = S_LOAD;
                  cnt_d   = '0;
               end else if (i_rx_data == 8'h43) begin
                  state_d = S_RUN;
               end else if (i_rx_data == 8'h53) begin
                  state_d = S_STEP;
               end
            end
         end

         S_LOAD: begin
            if (i_rx_valid) begin
               word_d = {word_q[23:0], i_rx_data};
               cnt_d  = cnt_q + 2'd1;
               if (cnt_q == 2'd3) state_d = S_WRITE;
            end
         end

         S_WRITE: begin
            o_write_instruction_mem = 1'b1;
            o_instruction_mem_addr  = addr_q;
            o_instruction_mem_data  = word_q;
            // HALT or the last slot ends the load; never wrap to 0
            if (word_q == 32'hFFFF_FFFF || addr_q == LAST_ADDR) begin
               addr_d  = '0;
               state_d = S_IDLE;
            end else begin
               addr_d  = addr_q + 32'd4;
               state_d = S_LOAD;
            end
         end

         S_RUN: begin
            o_stop = i_end;
            if (i_end) begin
               idx_d   = '0;
               state_d = S_DADDR;
            end
         end

         S_STEP: begin
            o_stop  = i_end;
            idx_d   = '0;
            state_d = S_DADDR;
         end

         S_DADDR, S_DCAP, S_DSEND, S_DWAIT: begin
            // address held through the whole word so capture is stable
            if (is_reg) begin
               o_r_addr_registers = idx_q[NB_REG_ADDR-1:0];
            end else begin
               o_r_addr_data_mem = 5'({dm_idx, 2'b00});
            end
            if (state_q == S_DADDR) begin
               state_d = S_DCAP;
            end else if (state_q == S_DCAP) begin
               word_d  = is_reg ? i_r_data_registers : i_r_data_data_mem;
               cnt_d   = '0;
               state_d = S_DSEND;
            end else begin
               unique case (cnt_q)
                  2'd0: o_tx_data = word_q[31:24];
                  2'd1: o_tx_data = word_q[23:16];
                  2'd2: o_tx_data = word_q[15:8];
                  default: o_tx_data = word_q[7:0];
               endcase
               if (state_q == S_DSEND) begin
                  o_tx_start = 1'b1;
                  state_d    = S_DWAIT;
               end else if (i_tx_done) begin
                  if (cnt_q != 2'd3) begin
                     cnt_d   = cnt_q + 2'd1;
                     state_d = S_DSEND;
                  end else if (idx_q == LAST_IDX) begin
                     idx_d   = '0;
                     state_d = S_IDLE;
                  end else begin
                     idx_d   = idx_q + 1'b1;
                     state_d = S_DADDR;
                  end
               end
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

endmodule
